change_dispenser: RTL

//  Payout end of the vending sale interface. Accepts one settled transaction
//  (goods code + change amount) per valid/ready handshake, then drives the

---
 rtl/change_dispenser.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : change_dispenser
// Brief    : Vending payout. Releases the goods, then pays change greedily
//            in 5/1-yuan coins. Each item uses a req/ack handshake that is
//            guarded by a watchdog.
// Revision : 1.0  initial release
// ============================================================================
module change_dispenser #(
  parameter int ACK_TIMEOUT = 60,
  parameter int AMT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pay_valid,
  output logic             pay_ready,
  input  logic [2:0]       pay_goods,
  input  logic [AMT_W-1:0] pay_change,
  output logic             vend_req,
  output logic [2:0]       vend_code,
  input  logic             vend_ack,
  output logic             coin5_req,
  output logic             coin1_req,
  input  logic             coin_ack,
  output logic             done,
  output logic             fault,
  input  logic             clear_fault,
  output logic [AMT_W-1:0] paid_total
);

  localparam int               WD_W      = $clog2(ACK_TIMEOUT);
  localparam logic [WD_W-1:0]  C_WD_LAST = WD_W'(ACK_TIMEOUT - 1);
  localparam logic [WD_W-1:0]  C_WD_ONE  = WD_W'(1);
  localparam logic [AMT_W-1:0] C_FIVE    = AMT_W'(5);
  localparam logic [AMT_W-1:0] C_ONE     = AMT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VEND  = 3'd1,
    S_PAY5  = 3'd2,
    S_PAY1  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [2:0]       code_q, code_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      paid_q  <= '0;
      code_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      paid_q  <= paid_d;
      code_q  <= code_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    paid_d  = paid_q;
    code_d  = code_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (pay_valid) begin
          code_d  = pay_goods;
          rem_d   = pay_change;
          paid_d  = '0;
          wdog_d  = '0;
          state_d = (pay_goods != 3'd0) ? S_VEND : S_GAP;
        end
      end
      S_VEND: begin
        if (vend_ack) begin
          state_d = S_GAP;
        end else if (wdog_q == C_WD_LAST) begin
          state_d = S_FAULT;
        end else begin
          wdog_d = wdog_q + C_WD_ONE;
        end
      end
      S_PAY5: begin
        // Ack is checked before expiry so a last-cycle ack still counts.
        if (coin_ack) begin
          if (rem_q >= C_FIVE) begin
            rem_d  = rem_q - C_FIVE;
            paid_d = paid_q + C_FIVE;
          end
          state_d = S_GAP;
        end else if (wdog_q == C_WD_LAST) begin
          state_d = S_FAULT;
        end else begin
          wdog_d = wdog_q + C_WD_ONE;
        end
      end
      S_PAY1: begin
        if (coin_ack) begin
          if (rem_q >= C_ONE) begin
            rem_d  = rem_q - C_ONE;
            paid_d = paid_q + C_ONE;
          end
          state_d = S_GAP;
        end else if (wdog_q == C_WD_LAST) begin
          state_d = S_FAULT;
        end else begin
          wdog_d = wdog_q + C_WD_ONE;
        end
      end
      S_GAP: begin
        wdog_d = '0;
        if (rem_q >= C_FIVE) begin
          state_d = S_PAY5;
        end else if (rem_q >= C_ONE) begin
          state_d = S_PAY1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clear_fault) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pay_ready  = (state_q == S_IDLE);
  assign vend_req   = (state_q == S_VEND);
  assign coin5_req  = (state_q == S_PAY5);
  assign coin1_req  = (state_q == S_PAY1);
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign vend_code  = code_q;
  assign paid_total = paid_q;

endmodule
`default_nettype wire
